// File: rtl/core_pkg.sv
// Shared widths, opcode encodings and the register-writing predicate
// used across the writeback slice of the 8-bit core.
package core_pkg;
  localparam int DATA_W = 8;
  localparam int REG_AW = 3;
  localparam int OPC_W  = 2;
  localparam int NREGS  = 2 ** REG_AW;

  localparam logic [OPC_W-1:0] OP_LDI = 2'b00;
  localparam logic [OPC_W-1:0] OP_ALU = 2'b01;
  localparam logic [OPC_W-1:0] OP_STR = 2'b10;
  localparam logic [OPC_W-1:0] OP_NOP = 2'b11;

  function automatic logic writes_reg(input logic [OPC_W-1:0] op);
    return (op == OP_LDI) || (op == OP_ALU);
  endfunction
endpackage

// File: rtl/regfile_8x8.sv
// Architectural register file: one synchronous write port, two
// asynchronous read ports, synchronous active-low clear of every entry.
module regfile_8x8
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  // Clear wins over a pending write so the file is all-zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];
endmodule

// File: rtl/ex_wb_stage.sv
// EX->WB pipeline register, writeback value select and register file
// with write-through bypass on both decode read ports.
module ex_wb_stage
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [OPC_W-1:0]  ex_opcode,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] ex_immval,
  input  logic              stall,
  input  logic              flush,
  input  logic [REG_AW-1:0] rs_a,
  input  logic [REG_AW-1:0] rs_b,
  output logic [DATA_W-1:0] rd_a_data,
  output logic [DATA_W-1:0] rd_b_data,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data
);
  logic              wb_valid_q, wb_valid_d;
  logic [OPC_W-1:0]  wb_op_q,    wb_op_d;
  logic [REG_AW-1:0] wb_rd_q,    wb_rd_d;
  logic [DATA_W-1:0] wb_data_q,  wb_data_d;
  logic [DATA_W-1:0] rf_a_data, rf_b_data;

  // Flush only kills the valid bit; the stale fields are harmless once invalid.
  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_op_d    = wb_op_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (flush) begin
      wb_valid_d = 1'b0;
    end else if (!stall) begin
      wb_valid_d = ex_valid;
      wb_op_d    = ex_opcode;
      wb_rd_d    = ex_rd;
      case (ex_opcode)
        OP_LDI:  wb_data_d = ex_immval;
        OP_ALU:  wb_data_d = ex_result;
        default: wb_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_op_q    <= OP_NOP;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_op_q    <= wb_op_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_we    = wb_valid_q & writes_reg(wb_op_q);
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;

  // The WB entry commits on the next edge, including edges where it is stalled or flushed.
  regfile_8x8 u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_we),
    .waddr   (wb_rd_q),
    .wdata   (wb_data_q),
    .raddr_a (rs_a),
    .raddr_b (rs_b),
    .rdata_a (rf_a_data),
    .rdata_b (rf_b_data)
  );

  assign rd_a_data = (wb_we && (wb_rd_q == rs_a)) ? wb_data_q : rf_a_data;
  assign rd_b_data = (wb_we && (wb_rd_q == rs_b)) ? wb_data_q : rf_b_data;
endmodule
